// File: rtl/hazard_ctrl.sv
// Hazard and flow control for the 16-bit five-stage core: load-use bubbles,
// branch squash, memory-wait freeze, halt drain and saturating event counters.
module hazard_ctrl #(
   parameter int CNT_W        = 16,
   parameter int DRAIN_CYCLES = 3
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             id_valid,
   input  logic [3:0]       id_rs,
   input  logic [3:0]       id_rt,
   input  logic             id_uses_rs,
   input  logic             id_uses_rt,
   input  logic             id_halt,
   input  logic             ex_memtoreg,
   input  logic             ex_rf_write,
   input  logic [3:0]       ex_rf_write_reg,
   input  logic             ex_branch_taken,
   input  logic             mem_busy,
   output logic             pc_wen,
   output logic             ifid_wen,
   output logic             ifid_flush,
   output logic             idex_wen,
   output logic             idex_stall,
   output logic             idex_flush,
   output logic             halted,
   output logic [CNT_W-1:0] stall_cnt,
   output logic [CNT_W-1:0] flush_cnt
);

   typedef enum logic [1:0] {RUN, DRAIN, HALTED} state_t;

   localparam logic [2:0] DRAIN_LD = 3'(DRAIN_CYCLES);

   state_t     state, state_nxt;
   logic [2:0] drain_cnt, drain_cnt_nxt;
   logic       lu, stall_inc, flush_inc;

   assign lu = id_valid & ex_memtoreg & ex_rf_write & (ex_rf_write_reg != 4'd0) &
               ((id_uses_rs & (id_rs == ex_rf_write_reg)) |
                (id_uses_rt & (id_rt == ex_rf_write_reg)));

   always_comb begin
      state_nxt     = state;
      drain_cnt_nxt = drain_cnt;
      pc_wen        = 1'b1;
      ifid_wen      = 1'b1;
      idex_wen      = 1'b1;
      ifid_flush    = 1'b0;
      idex_stall    = 1'b0;
      idex_flush    = 1'b0;
      halted        = 1'b0;
      stall_inc     = 1'b0;
      flush_inc     = 1'b0;
      unique case (state)
         RUN: begin
            if (mem_busy) begin
               pc_wen   = 1'b0;
               ifid_wen = 1'b0;
               idex_wen = 1'b0;
            end else if (ex_branch_taken) begin
               idex_flush = 1'b1;
               ifid_flush = 1'b1;
               flush_inc  = 1'b1;
            end else if (lu) begin
               pc_wen     = 1'b0;
               ifid_wen   = 1'b0;
               idex_stall = 1'b1;
               stall_inc  = 1'b1;
            end else if (id_valid && id_halt) begin
               state_nxt     = DRAIN;
               drain_cnt_nxt = DRAIN_LD;
            end
         end
         DRAIN: begin
            pc_wen   = 1'b0;
            ifid_wen = 1'b0;
            if (mem_busy) begin
               idex_wen = 1'b0;
            end else begin
               idex_stall    = 1'b1;
               drain_cnt_nxt = drain_cnt - 3'd1;
               if (drain_cnt <= 3'd1) state_nxt = HALTED;
            end
         end
         HALTED: begin
            pc_wen   = 1'b0;
            ifid_wen = 1'b0;
            idex_wen = 1'b0;
            halted   = 1'b1;
         end
         default: state_nxt = RUN;
      endcase
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state     <= RUN;
         drain_cnt <= 3'd0;
         stall_cnt <= '0;
         flush_cnt <= '0;
      end else begin
         state     <= state_nxt;
         drain_cnt <= drain_cnt_nxt;
         // saturate at all-ones so long runs never wrap back to small values
         if (stall_inc && (stall_cnt != '1)) stall_cnt <= stall_cnt + CNT_W'(1);
         if (flush_inc && (flush_cnt != '1)) flush_cnt <= flush_cnt + CNT_W'(1);
      end
   end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed self-checking bench for hazard_ctrl.
module tb_hazard_ctrl;

   logic        clk = 1'b0;
   logic        rst;
   logic        id_valid, id_uses_rs, id_uses_rt, id_halt;
   logic [3:0]  id_rs, id_rt, ex_rf_write_reg;
   logic        ex_memtoreg, ex_rf_write, ex_branch_taken, mem_busy;
   logic        pc_wen, ifid_wen, ifid_flush, idex_wen, idex_stall, idex_flush, halted;
   logic [15:0] stall_cnt, flush_cnt;

   int checks = 0;
   int errors = 0;

   hazard_ctrl #(.CNT_W(16), .DRAIN_CYCLES(3)) dut (
      .clk(clk), .rst(rst),
      .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
      .id_uses_rs(id_uses_rs), .id_uses_rt(id_uses_rt), .id_halt(id_halt),
      .ex_memtoreg(ex_memtoreg), .ex_rf_write(ex_rf_write),
      .ex_rf_write_reg(ex_rf_write_reg), .ex_branch_taken(ex_branch_taken),
      .mem_busy(mem_busy),
      .pc_wen(pc_wen), .ifid_wen(ifid_wen), .ifid_flush(ifid_flush),
      .idex_wen(idex_wen), .idex_stall(idex_stall), .idex_flush(idex_flush),
      .halted(halted), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_in();
      id_valid = 0; id_rs = 0; id_rt = 0; id_uses_rs = 0; id_uses_rt = 0; id_halt = 0;
      ex_memtoreg = 0; ex_rf_write = 0; ex_rf_write_reg = 0;
      ex_branch_taken = 0; mem_busy = 0;
   endtask

   task automatic set_lu(input logic [3:0] r);
      id_valid = 1; id_rs = r; id_uses_rs = 1;
      ex_memtoreg = 1; ex_rf_write = 1; ex_rf_write_reg = r;
   endtask

   initial begin
      rst = 0;
      idle_in();
      #1;
      chk("rst_pc_wen", pc_wen, 1);
      chk("rst_idex_wen", idex_wen, 1);
      chk("rst_halted", halted, 0);
      chk("rst_stall_cnt", stall_cnt, 0);
      chk("rst_flush_cnt", flush_cnt, 0);
      #12 rst = 1;
      step();

      chk("idle_pc_wen", pc_wen, 1);
      chk("idle_ifid_wen", ifid_wen, 1);
      chk("idle_idex_wen", idex_wen, 1);
      chk("idle_stall", idex_stall, 0);
      chk("idle_flush", idex_flush, 0);
      chk("idle_ifid_flush", ifid_flush, 0);

      // load-use on rs
      set_lu(4'd5);
      #1;
      chk("lu_pc_wen", pc_wen, 0);
      chk("lu_ifid_wen", ifid_wen, 0);
      chk("lu_idex_wen", idex_wen, 1);
      chk("lu_stall", idex_stall, 1);
      step();
      idle_in();
      chk("lu_stall_cnt", stall_cnt, 1);

      // register 0 never hazards
      set_lu(4'd0);
      #1;
      chk("r0_stall", idex_stall, 0);
      chk("r0_pc_wen", pc_wen, 1);
      step();
      idle_in();
      chk("r0_stall_cnt", stall_cnt, 1);

      // load-use on rt
      id_valid = 1; id_rt = 4'd7; id_uses_rt = 1; id_rs = 4'd2; id_uses_rs = 1;
      ex_memtoreg = 1; ex_rf_write = 1; ex_rf_write_reg = 4'd7;
      #1;
      chk("rt_stall", idex_stall, 1);
      id_uses_rt = 0;
      #1;
      chk("rt_unused_stall", idex_stall, 0);
      id_uses_rt = 1;
      step();
      idle_in();
      chk("rt_stall_cnt", stall_cnt, 2);

      // branch beats load-use
      set_lu(4'd3);
      ex_branch_taken = 1;
      #1;
      chk("br_idex_flush", idex_flush, 1);
      chk("br_ifid_flush", ifid_flush, 1);
      chk("br_pc_wen", pc_wen, 1);
      chk("br_stall", idex_stall, 0);
      step();
      idle_in();
      chk("br_flush_cnt", flush_cnt, 1);
      chk("br_stall_cnt", stall_cnt, 2);

      // mem_busy holds off a branch
      ex_branch_taken = 1; mem_busy = 1;
      #1;
      chk("busy_pc_wen", pc_wen, 0);
      chk("busy_ifid_wen", ifid_wen, 0);
      chk("busy_idex_wen", idex_wen, 0);
      chk("busy_flush", idex_flush, 0);
      step();
      chk("busy_flush_cnt", flush_cnt, 1);
      mem_busy = 0;
      #1;
      chk("rel_flush", idex_flush, 1);
      step();
      idle_in();
      chk("rel_flush_cnt", flush_cnt, 2);

      // saturation: 2 + 65536 increments clips at all-ones
      set_lu(4'd9);
      for (int i = 0; i < 65536; i++) step();
      chk("sat_stall_cnt", stall_cnt, 16'hFFFF);
      step();
      chk("sat_hold", stall_cnt, 16'hFFFF);
      idle_in();

      // halt drain with a 2-cycle memory wait
      id_valid = 1; id_halt = 1;
      #1;
      chk("hlt_pc_wen", pc_wen, 1);
      chk("hlt_stall", idex_stall, 0);
      step();
      idle_in();
      ex_branch_taken = 1;
      set_lu(4'd4);
      #1;
      chk("d1_pc_wen", pc_wen, 0);
      chk("d1_stall", idex_stall, 1);
      chk("d1_idex_wen", idex_wen, 1);
      chk("d1_no_flush", idex_flush, 0);
      chk("d1_halted", halted, 0);
      step();
      idle_in();
      chk("d_flush_cnt", flush_cnt, 2);
      mem_busy = 1;
      #1;
      chk("dbusy_idex_wen", idex_wen, 0);
      chk("dbusy_pc_wen", pc_wen, 0);
      step();
      chk("dbusy2_halted", halted, 0);
      step();
      mem_busy = 0;
      #1;
      chk("d2_stall", idex_stall, 1);
      chk("d2_halted", halted, 0);
      step();
      chk("d3_stall", idex_stall, 1);
      chk("d3_halted", halted, 0);
      step();
      chk("h_halted", halted, 1);
      chk("h_pc_wen", pc_wen, 0);
      chk("h_idex_wen", idex_wen, 0);
      chk("h_stall", idex_stall, 0);
      id_valid = 1; ex_branch_taken = 1;
      step(); step(); step();
      chk("h_sticky", halted, 1);
      chk("h_flush_cnt", flush_cnt, 2);
      idle_in();

      // async reset out of HALTED, no clock edge
      #2 rst = 0;
      #1;
      chk("ar_halted", halted, 0);
      chk("ar_stall_cnt", stall_cnt, 0);
      chk("ar_flush_cnt", flush_cnt, 0);
      chk("ar_pc_wen", pc_wen, 1);
      #10 rst = 1;
      step();
      chk("post_idex_wen", idex_wen, 1);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
